// File: rtl/spi_arbiter_if.sv
// Requester-side bus of the SPI arbiter:
// request fields in, accept and response handshake out.
interface spi_arbiter_if #(
  parameter int N_REQ = 3,
  parameter int SEL_W = 2,
  parameter int O_BW  = 8,
  parameter int I_BW  = 8
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_write;
  logic [N_REQ*SEL_W-1:0] req_slave;
  logic [N_REQ*O_BW-1:0]  req_wdata;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ-1:0]       rsp_valid;
  logic [I_BW-1:0]        rsp_rdata;
  logic                   rsp_err;
  logic                   busy;

  modport master (
    output req_valid,
    output req_write,
    output req_slave,
    output req_wdata,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata,
    input  rsp_err,
    input  busy
  );

  modport slave (
    input  req_valid,
    input  req_write,
    input  req_slave,
    input  req_wdata,
    output req_ready,
    output rsp_valid,
    output rsp_rdata,
    output rsp_err,
    output busy
  );
endinterface

// File: rtl/spi_arbiter.sv
// Round-robin arbiter/sequencer sharing one spi_core master
// between several requesters, with CS gap and watchdog.
module spi_arbiter #(
  parameter int          N_REQ      = 3,
  parameter int          N_SLAVES   = 1,
  parameter int          SEL_W      = 2,
  parameter int          O_BW       = 8,
  parameter int          I_BW       = 8,
  parameter int          GAP_CYCLES = 2,
  parameter logic [15:0] TIMEOUT    = 16'd1023
) (
  input  logic                clk,
  input  logic                rstn,
  spi_arbiter_if.slave        bus,
  output logic [O_BW-1:0]     core_odata,
  output logic [N_SLAVES-1:0] core_send,
  output logic [N_SLAVES-1:0] core_recv,
  input  logic                core_ready,
  input  logic [I_BW-1:0]     core_idata
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ISSUE     = 3'd1;
  localparam logic [2:0] WAIT_BUSY = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] GAP       = 3'd4;

  localparam logic [15:0] TO_LAST  = TIMEOUT - 16'd1;
  localparam logic [15:0] GAP_LAST =
    16'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [2:0]  AFTER    =
    (GAP_CYCLES > 0) ? GAP : IDLE;

  logic [2:0]          state;
  logic [2:0]          state_d;
  logic [PW-1:0]       ptr;
  logic [PW-1:0]       gidx;
  logic [PW-1:0]       gnt;
  logic                found;
  logic                g_write;
  logic [SEL_W-1:0]    g_slave;
  logic [O_BW-1:0]     g_wdata;
  logic                g_bad;
  logic [N_REQ-1:0]    gnt_oh;
  logic [N_REQ-1:0]    gidx_oh;
  logic                wr;
  logic [SEL_W-1:0]    sel;
  logic [N_SLAVES-1:0] sel_oh;
  logic                bad_pend;
  logic [15:0]         tcnt;
  logic [15:0]         gcnt;
  logic                to_hit;
  logic                gap_done;
  logic                take;

  function automatic int rr_idx(
    input logic [PW-1:0] p,
    input int            k
  );
    return (int'(p) + k) % N_REQ;
  endfunction

  // first valid requester at or after the pointer
  always_comb begin
    found   = 1'b0;
    gnt     = '0;
    g_write = 1'b0;
    g_slave = '0;
    g_wdata = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && bus.req_valid[rr_idx(ptr, k)]) begin
        found   = 1'b1;
        gnt     = PW'(rr_idx(ptr, k));
        g_write = bus.req_write[rr_idx(ptr, k)];
        g_slave =
          bus.req_slave[rr_idx(ptr, k)*SEL_W +: SEL_W];
        g_wdata =
          bus.req_wdata[rr_idx(ptr, k)*O_BW +: O_BW];
      end
    end
  end

  always_comb begin
    gnt_oh  = '0;
    gidx_oh = '0;
    sel_oh  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      gnt_oh[i]  = (gnt == PW'(i));
      gidx_oh[i] = (gidx == PW'(i));
    end
    for (int s = 0; s < N_SLAVES; s++)
      sel_oh[s] = (int'(sel) == s);
  end

  assign g_bad    = int'(g_slave) >= N_SLAVES;
  assign take     = core_ready && found;
  assign to_hit   = (tcnt == TO_LAST);
  assign gap_done = (gcnt == GAP_LAST);

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:
        if (take) state_d = g_bad ? GAP : ISSUE;
      ISSUE:
        state_d = WAIT_BUSY;
      WAIT_BUSY:
        if (to_hit)           state_d = AFTER;
        else if (!core_ready) state_d = WAIT_DONE;
      WAIT_DONE:
        if (core_ready || to_hit) state_d = AFTER;
      GAP:
        if (bad_pend)      state_d = AFTER;
        else if (gap_done) state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= IDLE;
      ptr           <= '0;
      gidx          <= '0;
      wr            <= 1'b0;
      sel           <= '0;
      bad_pend      <= 1'b0;
      tcnt          <= '0;
      gcnt          <= '0;
      core_odata    <= '0;
      core_send     <= '0;
      core_recv     <= '0;
      bus.req_ready <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      state         <= state_d;
      bus.busy      <= (state_d != IDLE);
      bus.req_ready <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      core_send     <= '0;
      core_recv     <= '0;
      unique case (state)
        IDLE: begin
          if (take) begin
            bus.req_ready <= gnt_oh;
            gidx          <= gnt;
            ptr           <= (gnt == PW'(N_REQ - 1))
                             ? '0 : gnt + 1'b1;
            wr            <= g_write;
            sel           <= g_slave;
            core_odata    <= g_wdata;
            bad_pend      <= g_bad;
            gcnt          <= '0;
          end
        end
        ISSUE: begin
          tcnt <= '0;
          if (wr) core_send <= sel_oh;
          else    core_recv <= sel_oh;
        end
        WAIT_BUSY: begin
          if (to_hit) begin
            bus.rsp_valid <= gidx_oh;
            bus.rsp_err   <= 1'b1;
            gcnt          <= '0;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        WAIT_DONE: begin
          // a completion on the expiry cycle still wins
          if (core_ready) begin
            bus.rsp_valid <= gidx_oh;
            bus.rsp_rdata <= wr ? '0 : core_idata;
            gcnt          <= '0;
          end else if (to_hit) begin
            bus.rsp_valid <= gidx_oh;
            bus.rsp_err   <= 1'b1;
            gcnt          <= '0;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        GAP: begin
          if (bad_pend) begin
            bus.rsp_valid <= gidx_oh;
            bus.rsp_err   <= 1'b1;
            bad_pend      <= 1'b0;
            gcnt          <= '0;
          end else begin
            gcnt <= gcnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
